// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller: state encoding,
// default bus widths and the timeout counter sizing helper.
package mem_access_ctrl_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width able to hold 0..timeout without wrapping.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Clearable, saturating up-counter that flags the last permitted wait cycle.
module mem_timeout_cnt
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = cnt_width(TIMEOUT)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: issues one req/ack transaction per
// load/store, stalls the pipeline until it completes, returns load data and
// aborts with a sticky error if the memory never acknowledges.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              timeout_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              timeout_err_q, timeout_err_d;
  logic              cnt_clr, cnt_en, cnt_done;

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .done_o (cnt_done)
  );

  // Next-state and output-register logic; registers hold unless a state acts.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    timeout_err_d = timeout_err_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (mem_read || mem_write) begin
          mem_addr_d  = addr;
          mem_wdata_d = wdata;
          mem_we_d    = mem_write;  // a write wins when both are requested
          mem_req_d   = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        // An ack on the final permitted cycle still counts as success.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            rdata_d       = mem_rdata;
            rdata_valid_d = 1'b1;
          end
          state_d = ST_DONE;
        end else if (cnt_done) begin
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        // Request inputs still belong to the finished instruction here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Stall rises in the same cycle a request appears, so it is combinational.
  always_comb begin
    stall = ((state_q == ST_IDLE) && (mem_read || mem_write)) || (state_q == ST_WAIT);
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int T = 15;

  logic        clk, rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid, timeout_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .timeout_err(timeout_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  // Reference state: last returned load data and sticky abort flag.
  logic [31:0] m_rdata;
  logic        m_terr;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          delay;     // WAIT cycle (1-based) carrying the ack
    logic [31:0] ad;
    int          exp_stall;
    int          exp_req;
    int          exp_valid;
    logic [31:0] exp_rdata;
    logic        exp_terr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // One access: request in cycle 0, hold inputs until stall drops (DONE).
  // An extra ack is pulsed in the cycle right after the real one, which is
  // DONE for a successful access and must be ignored.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int delay, input logic [31:0] ad,
                         input int idx,
                         output int n_stall, output int n_req, output int n_valid,
                         output int n_bad, output logic [31:0] last_rdata,
                         output logic last_terr);
    logic done;
    n_stall = 0; n_req = 0; n_valid = 0; n_bad = 0;
    last_rdata = '0; last_terr = 1'b0; done = 1'b0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    if (stall) n_stall++;
    if (mem_req) n_req++;
    chk("c0_rdata_valid", idx, rdata_valid, 1'b0);
    chk("c0_rdata", idx, rdata, m_rdata);
    for (int k = 1; k <= 64 && !done; k++) begin
      @(negedge clk);
      mem_ack   = (k == delay) || (k == delay + 1);
      mem_rdata = (k == delay) ? ad : $urandom;
      #1;
      if (mem_req) begin
        n_req++;
        if (mem_we !== wr || mem_addr !== a || mem_wdata !== wd) n_bad++;
      end
      if (rdata_valid) n_valid++;
      if (stall) n_stall++;
      else begin
        done = 1'b1;
        last_rdata = rdata;
        last_terr = timeout_err;
      end
    end
    chk("txn_completed", idx, done, 1'b1);
  endtask

  task automatic check_txn(input vec_t v, input int idx);
    int n_stall, n_req, n_valid, n_bad;
    logic [31:0] lr;
    logic lt;
    run_txn(v.rd, v.wr, v.a, v.wd, v.delay, v.ad, idx, n_stall, n_req, n_valid, n_bad, lr, lt);
    chk("stall_cycles", idx, n_stall, v.exp_stall);
    chk("req_cycles", idx, n_req, v.exp_req);
    chk("req_fields_stable", idx, n_bad, 0);
    chk("valid_pulses", idx, n_valid, v.exp_valid);
    chk("rdata", idx, lr, v.exp_rdata);
    chk("timeout_err", idx, lt, v.exp_terr);
    m_rdata = v.exp_rdata;
    m_terr  = v.exp_terr;
  endtask

  task automatic idle_cycle(input int idx);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; addr = $urandom; wdata = $urandom;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    #1;
    chk("idle_stall", idx, stall, 1'b0);
    chk("idle_req", idx, mem_req, 1'b0);
  endtask

  initial begin
    vec_t rv;
    logic succ;
    int sel;

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    m_rdata = '0; m_terr = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 3,   32'h99999999, 4,  3,  0, 32'h00000000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h10, 32'h0,        1,   32'h12345678, 2,  1,  1, 32'h12345678, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h80, 32'hA5A5A5A5, 2,   32'hFFFF0000, 3,  2,  0, 32'h12345678, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0,  32'h0,        1,   32'h11111111, 2,  1,  1, 32'h11111111, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h4,  32'h0,        1,   32'h22222222, 2,  1,  1, 32'h22222222, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h28, 32'h0,        15,  32'hCAFEF00D, 16, 15, 1, 32'hCAFEF00D, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h20, 32'h0,        255, 32'h0,        16, 15, 0, 32'hCAFEF00D, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h24, 32'h0,        5,   32'h0BADF00D, 6,  5,  1, 32'h0BADF00D, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 0, stall, 1'b0);
    chk("rst_mem_req", 0, mem_req, 1'b0);
    chk("rst_mem_we", 0, mem_we, 1'b0);
    chk("rst_rdata_valid", 0, rdata_valid, 1'b0);
    chk("rst_timeout_err", 0, timeout_err, 1'b0);
    chk("rst_rdata", 0, rdata, 32'h0);
    chk("rst_mem_addr", 0, mem_addr, 32'h0);
    chk("rst_mem_wdata", 0, mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) check_txn(vecs[i], i);

    // Reset in the second WAIT cycle: outputs clear without an edge, and a
    // late ack afterwards is ignored.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h30; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_req", 100, mem_req, 1'b1);
    #1;
    rst = 1'b1; mem_read = 1'b0;
    #1;
    chk("mid_rst_req", 100, mem_req, 1'b0);
    chk("mid_rst_stall", 100, stall, 1'b0);
    chk("mid_rst_valid", 100, rdata_valid, 1'b0);
    chk("mid_rst_terr", 100, timeout_err, 1'b0);
    chk("mid_rst_rdata", 100, rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
    #1;
    chk("late_ack_stall", 101, stall, 1'b0);
    chk("late_ack_req", 101, mem_req, 1'b0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("late_ack_valid", 101, rdata_valid, 1'b0);
    chk("late_ack_rdata", 101, rdata, 32'h0);
    m_rdata = '0; m_terr = 1'b0;

    // Randomized accesses against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) idle_cycle(200 + i);
      sel = $urandom_range(0, 2);
      rv.rd    = (sel != 1);
      rv.wr    = (sel != 0);
      rv.a     = $urandom;
      rv.wd    = $urandom;
      rv.delay = $urandom_range(1, T + 2);
      rv.ad    = $urandom;
      succ = (rv.delay <= T);
      rv.exp_stall = succ ? 1 + rv.delay : 1 + T;
      rv.exp_req   = succ ? rv.delay : T;
      rv.exp_valid = (succ && rv.rd && !rv.wr) ? 1 : 0;
      rv.exp_rdata = (rv.exp_valid == 1) ? rv.ad : m_rdata;
      rv.exp_terr  = m_terr | !succ;
      check_txn(rv, 200 + i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the MEM-stage data-memory access for the pipeline.
- Takes the registered mem_read/mem_write controls and the address/write data from the EX/MEM pipeline register, and drives a single-port data memory that uses a req/ack handshake with variable latency.
- Stalls the pipeline until the access completes, and returns load data.
- Flags a memory that never acknowledges, using a bounded timeout.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
TIMEOUT, 15, maximum WAIT_ACK cycles before abort (legal range 1..255)

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
mem_read  in  1  load request, from the EX/MEM register
mem_write  in  1  store request, from the EX/MEM register
addr  in  ADDR_W  access address
wdata  in  DATA_W  store data
stall  out  1  freezes the IF/ID/EX/MEM registers
rdata  out  DATA_W  load result, held until the next load completes
rdata_valid  out  1  one-cycle pulse when rdata is updated
timeout_err  out  1  sticky abort flag
mem_req  out  1  request to the memory
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion; one-cycle pulse
mem_rdata  in  DATA_W  read data, valid when mem_ack=1

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, cnt=0. stall, mem_req, mem_we, rdata_valid and timeout_err are 0. rdata, mem_addr and mem_wdata are 0.
- Reset asserted mid-access drops mem_req immediately. No retry follows reset.
- FSM states: IDLE, WAIT_ACK, DONE.
- IDLE:
  - When mem_read|mem_write=1: register addr and wdata into mem_addr and mem_wdata. Set mem_we=mem_write. Set mem_req=1 and cnt=0. Go to WAIT_ACK.
  - If both mem_read and mem_write are 1, the write wins (mem_we=1). No load data is returned in that case.
- WAIT_ACK:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable.
  - cnt increments every cycle.
  - On mem_ack=1: drop mem_req on the next edge. If a read, capture mem_rdata into rdata and set rdata_valid for the DONE cycle. Go to DONE.
  - If mem_ack=0 and cnt==TIMEOUT-1: drop mem_req, set timeout_err=1 (sticky until rst), leave rdata unchanged, set rdata_valid=0. Go to DONE.
  - mem_ack arriving on the same edge as the timeout counts as success.
- DONE: lasts one cycle with stall=0, so the pipeline advances. The mem_read/mem_write inputs are ignored in this cycle because they still belong to the finished instruction. Return to IDLE.
- stall is combinational: stall = (IDLE & (mem_read|mem_write)) | WAIT_ACK. It therefore rises in the same cycle the request appears.
- Latency:
  - The request-detect cycle is cycle 0, and mem_req=1 from cycle 1.
  - Earliest mem_ack is cycle 1, giving DONE in cycle 2.
  - Minimum stall is 2 cycles. In general, stall = 1 + (cycles until ack).
- mem_ack seen in IDLE or DONE is ignored.
- cnt is ceil(log2(TIMEOUT+1)) bits wide and never wraps, because it is cleared on entry to WAIT_ACK.
- No access is issued while stall is deasserted in IDLE with no request. Back-to-back accesses alternate IDLE→WAIT_ACK→DONE→IDLE, so there is at least one IDLE cycle between them.

Decomposition:
- Shared pipeline package holds the state encoding constants: ST_IDLE=2'd0, ST_WAIT=2'd1, ST_DONE=2'd2.
- The same package holds the default ADDR_W and DATA_W.
- One natural sub-module: mem_timeout_cnt. It is the clearable, saturating counter with clr, en and a done output compared against TIMEOUT.
- The FSM and output registers stay in mem_access_ctrl.

Test Plan:
1. Store, ack after 3 cycles: mem_write=1, addr=0x40, wdata=0xDEADBEEF.
   Expected: mem_req=1 with mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF for 3 cycles. stall high for 4 cycles. rdata_valid stays 0, rdata unchanged.
2. Load, immediate ack: mem_read=1, addr=0x10, mem_ack in the first WAIT cycle with mem_rdata=0x12345678.
   Expected: stall high for 2 cycles. rdata=0x12345678 with rdata_valid=1 in the DONE cycle only.
3. Timeout: mem_read=1, mem_ack held 0, TIMEOUT=15.
   Expected: mem_req high for exactly 15 cycles, then timeout_err=1 and stays 1. rdata unchanged. stall drops in DONE. A following access still completes normally.
4. Simultaneous mem_read=mem_write=1, wdata=0xA5A5A5A5.
   Expected: mem_we=1 and a write is performed. rdata_valid=0.
5. Reset mid-access: assert rst during WAIT_ACK (cycle 2).
   Expected: mem_req, stall and rdata_valid go to 0 without waiting for an edge. timeout_err=0. State is IDLE. A late mem_ack after reset is ignored.
6. Back-to-back loads to 0x0 then 0x4, each acked after 1 cycle.
   Expected: stall pattern 1,1,0,1,1,0. Two rdata_valid pulses with the correct data. mem_ack pulsed while in DONE is ignored.
